reg_file: RTL and testbench

Architectural register file with rename tags, sitting between the decoder and the ROB commit port. It receives committed register writes from the ROB (`reg_write`/`reg_rd`/`reg_val`/`commit_rob_pos`) and records which ROB entry will produce each register's next value. It answers the decoder's operand queries, returning either a ready value or the ROB position to wait on. All in-flight renames are discarded when the ROB signals rollback.

---
 rtl/reg_file_if.sv | 35 +++
 rtl/reg_file.sv | 58 +++++
 tb/tb_reg_file.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// reg_file_if: decoder/ROB side bus of the rename-tagged architectural register file.
interface reg_file_if #(
    parameter int DATA_W    = 32,
    parameter int REG_POS_W = 5,
    parameter int ROB_POS_W = 4
);
    logic                 rdy;
    logic                 rollback;
    logic                 issue;
    logic [REG_POS_W-1:0] issue_rd;
    logic [ROB_POS_W-1:0] issue_rob_pos;
    logic                 reg_write;
    logic [REG_POS_W-1:0] reg_rd;
    logic [DATA_W-1:0]    reg_val;
    logic [ROB_POS_W-1:0] commit_rob_pos;
    logic [REG_POS_W-1:0] rs1;
    logic [REG_POS_W-1:0] rs2;
    logic [DATA_W-1:0]    rs1_val;
    logic [DATA_W-1:0]    rs2_val;
    logic                 rs1_has_dep;
    logic                 rs2_has_dep;
    logic [ROB_POS_W-1:0] rs1_rob_pos;
    logic [ROB_POS_W-1:0] rs2_rob_pos;

    modport master (
        output rdy, rollback, issue, issue_rd, issue_rob_pos,
               reg_write, reg_rd, reg_val, commit_rob_pos, rs1, rs2,
        input  rs1_val, rs2_val, rs1_has_dep, rs2_has_dep, rs1_rob_pos, rs2_rob_pos
    );
    modport slave (
        input  rdy, rollback, issue, issue_rd, issue_rob_pos,
               reg_write, reg_rd, reg_val, commit_rob_pos, rs1, rs2,
        output rs1_val, rs2_val, rs1_has_dep, rs2_has_dep, rs1_rob_pos, rs2_rob_pos
    );
endinterface

// File: rtl/reg_file.sv
// reg_file: architectural registers with per-register busy/ROB-tag rename state,
// commit bypass on operand queries and rollback flush of all pending renames.
module reg_file #(
    parameter int DATA_W    = 32,
    parameter int REG_POS_W = 5,
    parameter int ROB_POS_W = 4
) (
    input logic       clk,
    input logic       rst,
    reg_file_if.slave bus
);
    localparam int NREG = 2 ** REG_POS_W;
    localparam int Q_W  = 1 + ROB_POS_W + DATA_W;

    logic [DATA_W-1:0]    vals [NREG];
    logic [ROB_POS_W-1:0] tags [NREG];
    logic [NREG-1:0]      busy;

    logic wr_en, wr_clears, iss_en;

    assign wr_en     = bus.rdy && bus.reg_write && bus.reg_rd != '0;
    assign wr_clears = busy[bus.reg_rd] && tags[bus.reg_rd] == bus.commit_rob_pos;
    assign iss_en    = bus.rdy && !bus.rollback && bus.issue && bus.issue_rd != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                vals[i] <= '0;
                tags[i] <= '0;
            end
            busy <= '0;
        end else if (bus.rdy) begin
            if (wr_en) begin
                vals[bus.reg_rd] <= bus.reg_val;
                if (wr_clears)
                    busy[bus.reg_rd] <= 1'b0;
            end
            // later assignments win: a same-register issue keeps the entry busy under the new tag
            if (bus.rollback)
                busy <= '0;
            else if (iss_en) begin
                busy[bus.issue_rd] <= 1'b1;
                tags[bus.issue_rd] <= bus.issue_rob_pos;
            end
        end
    end

    function automatic logic [Q_W-1:0] query(input logic [REG_POS_W-1:0] rs);
        logic byp;
        byp = bus.reg_write && bus.reg_rd == rs && busy[rs] && tags[rs] == bus.commit_rob_pos;
        return rs == '0 ? '0 :
               byp      ? {1'b0, tags[rs], bus.reg_val} :
                          {busy[rs], tags[rs], vals[rs]};
    endfunction

    assign {bus.rs1_has_dep, bus.rs1_rob_pos, bus.rs1_val} = query(bus.rs1);
    assign {bus.rs2_has_dep, bus.rs2_rob_pos, bus.rs2_val} = query(bus.rs2);
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scenario tasks push expected query results to a scoreboard and pop them
// against the live operand outputs.
module tb_reg_file;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_if #(.DATA_W(32), .REG_POS_W(5), .ROB_POS_W(4)) dif ();
    reg_file #(.DATA_W(32), .REG_POS_W(5), .ROB_POS_W(4)) dut (.clk(clk), .rst(rst), .bus(dif.slave));

    typedef struct {
        string       name;
        bit          port;
        logic [36:0] exp;
        logic [36:0] mask;
    } exp_t;

    localparam logic [36:0] ALL   = {37{1'b1}};
    localparam logic [36:0] NOPOS = {1'b1, 4'h0, 32'hFFFF_FFFF};

    exp_t        sb[$];
    exp_t        e;
    logic [36:0] obs;
    int          checks   = 0;
    int          failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dif.rdy = 1'b1; dif.rollback = 1'b0; dif.issue = 1'b0; dif.issue_rd = '0;
        dif.issue_rob_pos = '0; dif.reg_write = 1'b0; dif.reg_rd = '0; dif.reg_val = '0;
        dif.commit_rob_pos = '0;
    endtask

    task automatic push(input string name, input bit port, input logic [36:0] exp, input logic [36:0] mask);
        sb.push_back('{name, port, exp, mask});
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [3:0] pos);
        dif.issue = 1'b1; dif.issue_rd = rd; dif.issue_rob_pos = pos;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] pos);
        dif.reg_write = 1'b1; dif.reg_rd = rd; dif.reg_val = v; dif.commit_rob_pos = pos;
    endtask

    task automatic test_reset();
        idle(); dif.rs1 = 5'd5; dif.rs2 = 5'd0;
        rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
        push("reset_rs1", 0, 37'h0, ALL);
        push("reset_rs2", 1, 37'h0, ALL);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.port ? {dif.rs2_has_dep, dif.rs2_rob_pos, dif.rs2_val} : {dif.rs1_has_dep, dif.rs1_rob_pos, dif.rs1_val};
            checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                failures++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
            end
        end
        dif.rs1 = 5'd31; #1;
        push("reset_rs31", 0, 37'h0, ALL);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.port ? {dif.rs2_has_dep, dif.rs2_rob_pos, dif.rs2_val} : {dif.rs1_has_dep, dif.rs1_rob_pos, dif.rs1_val};
            checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                failures++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
            end
        end
    endtask

    task automatic test_issue_commit();
        idle(); do_issue(5'd3, 4'd7); tick();
        idle(); dif.rs1 = 5'd3; #1;
        push("dep_after_issue", 0, {1'b1, 4'd7, 32'h0}, ALL);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.port ? {dif.rs2_has_dep, dif.rs2_rob_pos, dif.rs2_val} : {dif.rs1_has_dep, dif.rs1_rob_pos, dif.rs1_val};
            checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                failures++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
            end
        end
        do_commit(5'd3, 32'h1234, 4'd7); #1;
        push("commit_bypass", 0, {1'b0, 4'd0, 32'h1234}, NOPOS);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.port ? {dif.rs2_has_dep, dif.rs2_rob_pos, dif.rs2_val} : {dif.rs1_has_dep, dif.rs1_rob_pos, dif.rs1_val};
            checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                failures++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
            end
        end
        tick(); idle(); #1;
        push("commit_stored", 0, {1'b0, 4'd7, 32'h1234}, ALL);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.port ? {dif.rs2_has_dep, dif.rs2_rob_pos, dif.rs2_val} : {dif.rs1_has_dep, dif.rs1_rob_pos, dif.rs1_val};
            checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                failures++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
            end
        end
    endtask

    task automatic test_rename_chain();
        idle(); do_issue(5'd4, 4'd2); tick();
        do_issue(5'd4, 4'd5); tick();
        idle(); do_commit(5'd4, 32'hAA, 4'd2); dif.rs1 = 5'd4; dif.rs2 = 5'd4; #1;
        push("stale_commit_no_bypass", 0, {1'b1, 4'd5, 32'h0}, ALL);
        push("stale_commit_no_bypass_rs2", 1, {1'b1, 4'd5, 32'h0}, ALL);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.port ? {dif.rs2_has_dep, dif.rs2_rob_pos, dif.rs2_val} : {dif.rs1_has_dep, dif.rs1_rob_pos, dif.rs1_val};
            checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                failures++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
            end
        end
        tick(); idle(); #1;
        push("stale_commit_stays_busy", 0, {1'b1, 4'd5, 32'hAA}, ALL);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.port ? {dif.rs2_has_dep, dif.rs2_rob_pos, dif.rs2_val} : {dif.rs1_has_dep, dif.rs1_rob_pos, dif.rs1_val};
            checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                failures++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
            end
        end
    endtask

    task automatic test_same_cycle();
        idle(); do_issue(5'd6, 4'd1); tick();
        idle(); do_commit(5'd6, 32'h5A5A, 4'd1); do_issue(5'd6, 4'd9); dif.rs1 = 5'd6; #1;
        push("same_cycle_bypass", 0, {1'b0, 4'd0, 32'h5A5A}, NOPOS);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.port ? {dif.rs2_has_dep, dif.rs2_rob_pos, dif.rs2_val} : {dif.rs1_has_dep, dif.rs1_rob_pos, dif.rs1_val};
            checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                failures++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
            end
        end
        tick(); idle(); #1;
        push("issue_wins_over_commit", 0, {1'b1, 4'd9, 32'h5A5A}, ALL);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.port ? {dif.rs2_has_dep, dif.rs2_rob_pos, dif.rs2_val} : {dif.rs1_has_dep, dif.rs1_rob_pos, dif.rs1_val};
            checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                failures++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
            end
        end
    endtask

    task automatic test_rollback();
        logic [4:0]  q_rs  [6] = '{5'd1, 5'd2, 5'd3, 5'd8, 5'd4, 5'd6};
        logic [36:0] q_exp [6] = '{{1'b0, 4'd0, 32'h0}, {1'b0, 4'd1, 32'h77}, {1'b0, 4'd2, 32'h1234},
                                   {1'b0, 4'd0, 32'h0}, {1'b0, 4'd5, 32'hAA}, {1'b0, 4'd9, 32'h5A5A}};
        idle(); do_issue(5'd1, 4'd0); tick();
        do_issue(5'd2, 4'd1); tick();
        do_issue(5'd3, 4'd2); tick();
        idle(); dif.rollback = 1'b1; do_issue(5'd8, 4'd3); do_commit(5'd2, 32'h77, 4'd1); tick();
        idle();
        for (int i = 0; i < 6; i++) begin
            dif.rs1 = q_rs[i]; #1;
            push($sformatf("rollback_rs%0d", q_rs[i]), 0, q_exp[i], ALL);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = e.port ? {dif.rs2_has_dep, dif.rs2_rob_pos, dif.rs2_val} : {dif.rs1_has_dep, dif.rs1_rob_pos, dif.rs1_val};
                checks++;
                if ((obs & e.mask) !== (e.exp & e.mask)) begin
                    failures++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_x0_rdy();
        idle(); do_commit(5'd0, 32'hFFFF, 4'd0); do_issue(5'd0, 4'd4); dif.rs1 = 5'd0; #1;
        push("x0_during_write", 0, 37'h0, ALL);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.port ? {dif.rs2_has_dep, dif.rs2_rob_pos, dif.rs2_val} : {dif.rs1_has_dep, dif.rs1_rob_pos, dif.rs1_val};
            checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                failures++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
            end
        end
        tick(); idle(); do_issue(5'd12, 4'd11); tick();
        idle(); dif.rdy = 1'b0; dif.rollback = 1'b1; do_issue(5'd10, 4'd6); do_commit(5'd11, 32'h99, 4'd0); tick();
        idle(); dif.rs1 = 5'd0; dif.rs2 = 5'd10; #1;
        push("x0_after_write", 0, 37'h0, ALL);
        push("rdy_low_no_issue", 1, 37'h0, ALL);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.port ? {dif.rs2_has_dep, dif.rs2_rob_pos, dif.rs2_val} : {dif.rs1_has_dep, dif.rs1_rob_pos, dif.rs1_val};
            checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                failures++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
            end
        end
        dif.rs1 = 5'd11; dif.rs2 = 5'd12; #1;
        push("rdy_low_no_write", 0, 37'h0, ALL);
        push("rdy_low_no_rollback", 1, {1'b1, 4'd11, 32'h0}, ALL);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.port ? {dif.rs2_has_dep, dif.rs2_rob_pos, dif.rs2_val} : {dif.rs1_has_dep, dif.rs1_rob_pos, dif.rs1_val};
            checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                failures++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        idle(); do_commit(5'd12, 32'hBEEF, 4'd11); do_issue(5'd13, 4'd12); dif.rs1 = 5'd12; dif.rs2 = 5'd13; #1;
        push("b2b_bypass_rs1", 0, {1'b0, 4'd0, 32'hBEEF}, NOPOS);
        push("b2b_issue_hidden_rs2", 1, 37'h0, ALL);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.port ? {dif.rs2_has_dep, dif.rs2_rob_pos, dif.rs2_val} : {dif.rs1_has_dep, dif.rs1_rob_pos, dif.rs1_val};
            checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                failures++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
            end
        end
        tick(); idle(); do_commit(5'd13, 32'hCAFE, 4'd12); #1;
        push("b2b_stored_rs1", 0, {1'b0, 4'd11, 32'hBEEF}, ALL);
        push("b2b_bypass_rs2", 1, {1'b0, 4'd0, 32'hCAFE}, NOPOS);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.port ? {dif.rs2_has_dep, dif.rs2_rob_pos, dif.rs2_val} : {dif.rs1_has_dep, dif.rs1_rob_pos, dif.rs1_val};
            checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                failures++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
            end
        end
        tick(); idle(); #1;
        push("b2b_stored_rs2", 1, {1'b0, 4'd12, 32'hCAFE}, ALL);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.port ? {dif.rs2_has_dep, dif.rs2_rob_pos, dif.rs2_val} : {dif.rs1_has_dep, dif.rs1_rob_pos, dif.rs1_val};
            checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                failures++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
            end
        end
    endtask

    initial begin
        idle(); dif.rs1 = '0; dif.rs2 = '0;
        test_reset();
        test_issue_commit();
        test_rename_chain();
        test_same_cycle();
        test_rollback();
        test_x0_rdy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
